// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf
//  Description : Two-entry skid buffer for one pipeline stage. Upstream
//                in_ready and downstream out_valid/out_data are all driven
//                straight from flops, so neither side sees a combinational
//                path through this stage. Honours its own bit of the
//                pipeline stall vector and a flush that empties the buffer.
//                Optional performance counters are built only when the
//                macro PIPE_STAGE_PERF_EN is defined; otherwise the perf
//                ports read as constant zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int WD        = 50,
  parameter int STAGE_IDX = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] out_data,
  output logic [1:0]    occ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_xfer_cnt
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [WD-1:0] main_q;
  logic [WD-1:0] skid_q;
  logic [WD-1:0] main_nxt;
  logic [WD-1:0] skid_nxt;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          stage_stall;
  logic          in_fire;
  logic          out_fire;
  logic          unused_stall;

  assign stage_stall  = stall[STAGE_IDX];
  assign in_fire      = in_valid & in_ready_q;
  assign out_fire     = out_valid_q & out_ready & ~stage_stall;
  // Only this stage's stall bit matters; the rest are deliberately ignored.
  assign unused_stall = ^stall;

  // State register plus the flopped handshake outputs and storage entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != ST_FULL);
      out_valid_q <= (state_nxt != ST_EMPTY);
      main_q      <= main_nxt;
      skid_q      <= skid_nxt;
    end
  end

  // Next-state logic; flush overrides any simultaneous transfer.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) state_nxt = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_nxt = ST_FULL;
          else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Entry update: main always holds the oldest word, skid the younger one.
  always_comb begin
    main_nxt = main_q;
    skid_nxt = skid_q;
    if (flush) begin
      main_nxt = '0;
      skid_nxt = '0;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) main_nxt = in_data;
        ST_ONE: begin
          if (in_fire && out_fire) main_nxt = in_data;
          else if (in_fire)        skid_nxt = in_data;
        end
        ST_FULL:  if (out_fire) main_nxt = skid_q;
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occ       = state;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] xfer_cnt_q;
  logic        stall_evt;

  assign stall_evt = out_valid_q & ~(out_ready & ~stage_stall);

  // Saturating event counters; cleared by reset only, never by flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (out_fire && (xfer_cnt_q != 32'hFFFF_FFFF))   xfer_cnt_q  <= xfer_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_xfer_cnt  = xfer_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_xfer_cnt  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_buf
//  Description : Directed vector table plus randomized scoreboard run for
//                pipe_stage_buf (WD=8, STAGE_IDX=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  occ;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_xfer_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(.WD(8), .STAGE_IDX(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ), .perf_stall_cnt(perf_stall_cnt), .perf_xfer_cnt(perf_xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic [5:0]  stall;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic [1:0]  occ;
    logic        ov;
    logic        ir;
    logic [7:0]  od;
    logic [31:0] sc;
    logic [31:0] xc;
  } vec_t;

  vec_t vecs[29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef PIPE_STAGE_PERF_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    logic [7:0] q[$];
    int         n_out;
    logic       ifire;
    logic       ofire;
    logic [7:0] front;

    //            rst flu stall      iv data   or  occ ov ir od     sc  xc
    vecs[0]  = '{1'b0,1'b0,6'b000000,1'b0,8'h00,1'b0,2'd0,1'b0,1'b0,8'h00, 0, 0};
    vecs[1]  = '{1'b1,1'b0,6'b000000,1'b1,8'h11,1'b1,2'd0,1'b0,1'b1,8'h00, 0, 0};
    vecs[2]  = '{1'b1,1'b0,6'b000000,1'b1,8'h11,1'b1,2'd1,1'b1,1'b1,8'h11, 0, 0};
    vecs[3]  = '{1'b1,1'b0,6'b000000,1'b1,8'h22,1'b1,2'd1,1'b1,1'b1,8'h22, 0, 1};
    vecs[4]  = '{1'b1,1'b0,6'b000000,1'b1,8'h33,1'b1,2'd1,1'b1,1'b1,8'h33, 0, 2};
    vecs[5]  = '{1'b1,1'b0,6'b000000,1'b0,8'h00,1'b1,2'd0,1'b0,1'b1,8'h33, 0, 3};
    vecs[6]  = '{1'b1,1'b0,6'b000000,1'b1,8'h0A,1'b0,2'd1,1'b1,1'b1,8'h0A, 0, 3};
    vecs[7]  = '{1'b1,1'b0,6'b000000,1'b1,8'h0B,1'b0,2'd2,1'b1,1'b0,8'h0A, 1, 3};
    vecs[8]  = '{1'b1,1'b0,6'b000000,1'b1,8'h0C,1'b0,2'd2,1'b1,1'b0,8'h0A, 2, 3};
    vecs[9]  = '{1'b1,1'b0,6'b000000,1'b1,8'h0C,1'b1,2'd1,1'b1,1'b1,8'h0B, 2, 4};
    vecs[10] = '{1'b1,1'b0,6'b000000,1'b1,8'h0C,1'b1,2'd1,1'b1,1'b1,8'h0C, 2, 5};
    vecs[11] = '{1'b1,1'b0,6'b000000,1'b0,8'h00,1'b1,2'd0,1'b0,1'b1,8'h0C, 2, 6};
    vecs[12] = '{1'b1,1'b0,6'b000100,1'b1,8'h44,1'b1,2'd1,1'b1,1'b1,8'h44, 2, 6};
    vecs[13] = '{1'b1,1'b0,6'b000100,1'b0,8'h00,1'b1,2'd1,1'b1,1'b1,8'h44, 3, 6};
    vecs[14] = '{1'b1,1'b0,6'b000100,1'b0,8'h00,1'b1,2'd1,1'b1,1'b1,8'h44, 4, 6};
    vecs[15] = '{1'b1,1'b0,6'b000100,1'b0,8'h00,1'b1,2'd1,1'b1,1'b1,8'h44, 5, 6};
    vecs[16] = '{1'b1,1'b0,6'b000100,1'b0,8'h00,1'b1,2'd1,1'b1,1'b1,8'h44, 6, 6};
    vecs[17] = '{1'b1,1'b0,6'b111011,1'b0,8'h00,1'b1,2'd0,1'b0,1'b1,8'h44, 6, 7};
    vecs[18] = '{1'b1,1'b0,6'b000000,1'b1,8'h01,1'b0,2'd1,1'b1,1'b1,8'h01, 6, 7};
    vecs[19] = '{1'b1,1'b0,6'b000000,1'b1,8'h02,1'b0,2'd2,1'b1,1'b0,8'h01, 7, 7};
    vecs[20] = '{1'b1,1'b1,6'b000000,1'b1,8'h55,1'b0,2'd0,1'b0,1'b1,8'h00, 8, 7};
    vecs[21] = '{1'b1,1'b0,6'b000000,1'b0,8'h00,1'b0,2'd0,1'b0,1'b1,8'h00, 8, 7};
    vecs[22] = '{1'b1,1'b0,6'b000000,1'b1,8'h66,1'b0,2'd1,1'b1,1'b1,8'h66, 8, 7};
    vecs[23] = '{1'b1,1'b1,6'b000000,1'b1,8'h55,1'b0,2'd0,1'b0,1'b1,8'h00, 9, 7};
    vecs[24] = '{1'b1,1'b0,6'b000000,1'b0,8'h00,1'b0,2'd0,1'b0,1'b1,8'h00, 9, 7};
    vecs[25] = '{1'b1,1'b0,6'b000000,1'b1,8'h01,1'b0,2'd1,1'b1,1'b1,8'h01, 9, 7};
    vecs[26] = '{1'b1,1'b0,6'b000000,1'b1,8'h02,1'b0,2'd2,1'b1,1'b0,8'h01,10, 7};
    vecs[27] = '{1'b0,1'b1,6'b000000,1'b1,8'h77,1'b0,2'd0,1'b0,1'b0,8'h00, 0, 0};
    vecs[28] = '{1'b1,1'b0,6'b000000,1'b0,8'h00,1'b0,2'd0,1'b0,1'b1,8'h00, 0, 0};

    rst_n = 1'b0; flush = 1'b0; stall = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Directed table: drive on falling edge, check just after the rising edge.
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      rst_n     = vecs[i].rst_n;
      flush     = vecs[i].flush;
      stall     = vecs[i].stall;
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d occ", i),       {30'd0, occ},       {30'd0, vecs[i].occ});
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
      chk($sformatf("v%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].ir});
      chk($sformatf("v%0d out_data", i),  {24'd0, out_data},  {24'd0, vecs[i].od});
      chk($sformatf("v%0d perf_stall", i), perf_stall_cnt, perf_exp(vecs[i].sc));
      chk($sformatf("v%0d perf_xfer", i),  perf_xfer_cnt,  perf_exp(vecs[i].xc));
    end

    // Randomized traffic with a scoreboard queue; buffer starts empty here.
    n_out = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      flush     = 1'b0;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = 6'($urandom_range(0, 63));
      stall[2]  = ($urandom_range(0, 3) == 0);
      ifire = in_valid & in_ready;
      ofire = out_valid & out_ready & ~stall[2];
      if (ofire) begin
        if (q.size() == 0) begin
          chk("rand spurious output", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          front = q.pop_front();
          chk("rand order", {24'd0, out_data}, {24'd0, front});
        end
        n_out++;
      end
      if (ifire) q.push_back(in_data);
    end

    // Drain whatever remains, bounded so a stuck buffer cannot hang the run.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1; stall = '0;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("drain spurious output", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          front = q.pop_front();
          chk("drain order", {24'd0, out_data}, {24'd0, front});
        end
        n_out++;
      end
    end
    @(posedge clk);
    #1;
    chk("drain queue empty", q.size(), 0);
    chk("drain occ", {30'd0, occ}, 32'd0);
    chk("rand perf_xfer", perf_xfer_cnt, perf_exp(n_out));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
